// File: rtl/rx_frame_check_if.sv
// Stream bundle for rx_frame_check: gearbox word input, payload output and
// per-frame status strobe.
interface rx_frame_check_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic [1:0]  in_mod;

    logic [31:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_mod;
    logic        out_err;

    logic        stat_valid;
    logic [15:0] stat_len;
    logic        stat_err_sfd;
    logic        stat_err_runt;
    logic        stat_err_giant;
    logic        stat_err_trunc;

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_mod,
        input  out_data, out_valid, out_sop, out_eop, out_mod, out_err,
        input  stat_valid, stat_len, stat_err_sfd, stat_err_runt,
               stat_err_giant, stat_err_trunc
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_mod,
        output out_data, out_valid, out_sop, out_eop, out_mod, out_err,
        output stat_valid, stat_len, stat_err_sfd, stat_err_runt,
               stat_err_giant, stat_err_trunc
    );
endinterface

// File: rtl/rx_frame_check.sv
// Strips and validates preamble/SFD from the 32-bit rx word stream, forwards
// DA..FCS with regenerated framing, and reports per-frame length and errors.
//
// state | meaning
// IDLE  | waiting for in_sop
// PRE   | first preamble word seen, expecting SFD word
// DATA  | forwarding payload words, counting length
// DROP  | bad preamble, discarding until in_eop
module rx_frame_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic            gmii_clk,
    input  logic            rst,
    rx_frame_check_if.slave fc_io
);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_e;

    localparam logic [31:0] PRE_WORD = 32'h5555_5555;
    localparam logic [31:0] SFD_WORD = 32'h5555_55D5;
    localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L    = 16'(MAX_LEN);

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic        first_q, first_d;
    logic        sfd_q, sfd_d;

    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;
    logic [1:0]  out_mod_q, out_mod_d;
    logic        out_err_q, out_err_d;

    logic        stat_valid_q, stat_valid_d;
    logic [15:0] stat_len_q, stat_len_d;
    logic        stat_sfd_q, stat_sfd_d;
    logic        stat_runt_q, stat_runt_d;
    logic        stat_giant_q, stat_giant_d;
    logic        stat_trunc_q, stat_trunc_d;

    logic        emit;
    logic [15:0] emit_len;
    logic        emit_sfd;
    logic        emit_trunc;
    logic [2:0]  add;
    logic [16:0] sum;
    logic [15:0] new_len;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        first_d      = first_q;
        sfd_d        = sfd_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        out_sop_d    = 1'b0;
        out_eop_d    = 1'b0;
        out_mod_d    = out_mod_q;
        out_err_d    = out_err_q;
        stat_valid_d = 1'b0;
        stat_len_d   = stat_len_q;
        stat_sfd_d   = stat_sfd_q;
        stat_runt_d  = stat_runt_q;
        stat_giant_d = stat_giant_q;
        stat_trunc_d = stat_trunc_q;
        emit         = 1'b0;
        emit_len     = len_q;
        emit_sfd     = sfd_q;
        emit_trunc   = 1'b0;
        add          = 3'd4;
        sum          = 17'd0;
        new_len      = len_q;

        if (fc_io.in_valid) begin
            if (fc_io.in_sop) begin
                // A sop mid-frame closes the old frame, then restarts sync on this word.
                if (state_q != IDLE) begin
                    emit       = 1'b1;
                    emit_len   = len_q;
                    emit_sfd   = sfd_q;
                    emit_trunc = 1'b1;
                    if (state_q == DATA) begin
                        out_valid_d = 1'b1;
                        out_eop_d   = 1'b1;
                        out_err_d   = 1'b1;
                        out_data_d  = '0;
                        out_mod_d   = '0;
                    end
                end
                len_d   = '0;
                first_d = 1'b0;
                sfd_d   = 1'b0;
                if (fc_io.in_data == PRE_WORD && !fc_io.in_eop) begin
                    state_d = PRE;
                end else begin
                    sfd_d = 1'b1;
                    if (fc_io.in_eop) begin
                        emit       = 1'b1;
                        emit_len   = '0;
                        emit_sfd   = 1'b1;
                        emit_trunc = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: ;
                    PRE: begin
                        if (fc_io.in_data == SFD_WORD && !fc_io.in_eop) begin
                            state_d = DATA;
                            len_d   = '0;
                            first_d = 1'b1;
                        end else begin
                            sfd_d = 1'b1;
                            if (fc_io.in_eop) begin
                                emit     = 1'b1;
                                emit_len = '0;
                                emit_sfd = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                state_d = DROP;
                            end
                        end
                    end
                    DATA: begin
                        if (fc_io.in_eop && fc_io.in_mod != 2'd0) add = {1'b0, fc_io.in_mod};
                        sum         = {1'b0, len_q} + 17'(add);
                        new_len     = sum[16] ? 16'hFFFF : sum[15:0];
                        len_d       = new_len;
                        first_d     = 1'b0;
                        out_valid_d = 1'b1;
                        out_data_d  = fc_io.in_data;
                        out_sop_d   = first_q;
                        out_eop_d   = fc_io.in_eop;
                        out_mod_d   = fc_io.in_eop ? fc_io.in_mod : 2'd0;
                        out_err_d   = fc_io.in_eop &&
                                      (sfd_q || new_len < MIN_L || new_len > MAX_L);
                        if (fc_io.in_eop) begin
                            emit     = 1'b1;
                            emit_len = new_len;
                            emit_sfd = sfd_q;
                            state_d  = IDLE;
                        end
                    end
                    DROP: begin
                        if (fc_io.in_eop) begin
                            emit     = 1'b1;
                            emit_len = '0;
                            emit_sfd = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        if (emit) begin
            stat_valid_d = 1'b1;
            stat_len_d   = emit_len;
            stat_sfd_d   = emit_sfd;
            stat_runt_d  = emit_len < MIN_L;
            stat_giant_d = emit_len > MAX_L;
            stat_trunc_d = emit_trunc;
        end
    end

    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            first_q      <= 1'b0;
            sfd_q        <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_mod_q    <= '0;
            out_err_q    <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_len_q   <= '0;
            stat_sfd_q   <= 1'b0;
            stat_runt_q  <= 1'b0;
            stat_giant_q <= 1'b0;
            stat_trunc_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            first_q      <= first_d;
            sfd_q        <= sfd_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_mod_q    <= out_mod_d;
            out_err_q    <= out_err_d;
            stat_valid_q <= stat_valid_d;
            stat_len_q   <= stat_len_d;
            stat_sfd_q   <= stat_sfd_d;
            stat_runt_q  <= stat_runt_d;
            stat_giant_q <= stat_giant_d;
            stat_trunc_q <= stat_trunc_d;
        end
    end

    assign fc_io.out_data       = out_data_q;
    assign fc_io.out_valid      = out_valid_q;
    assign fc_io.out_sop        = out_sop_q;
    assign fc_io.out_eop        = out_eop_q;
    assign fc_io.out_mod        = out_mod_q;
    assign fc_io.out_err        = out_err_q;
    assign fc_io.stat_valid     = stat_valid_q;
    assign fc_io.stat_len       = stat_len_q;
    assign fc_io.stat_err_sfd   = stat_sfd_q;
    assign fc_io.stat_err_runt  = stat_runt_q;
    assign fc_io.stat_err_giant = stat_giant_q;
    assign fc_io.stat_err_trunc = stat_trunc_q;

endmodule

// File: tb/tb_rx_frame_check.sv
// Bench for rx_frame_check: table of whole frames plus hand sequences for
// truncation, single-word frames and mid-frame reset, checked via scoreboards.
module tb_rx_frame_check;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
        logic        err;
    } out_t;

    typedef struct packed {
        logic [15:0] len;
        logic        sfd;
        logic        runt;
        logic        giant;
        logic        trunc;
    } stat_t;

    typedef struct packed {
        logic [31:0] p0;
        logic [31:0] p1;
        int          nw;
        logic [1:0]  md;
        logic        fwd;
        logic [15:0] len;
        logic        sfd;
        logic        runt;
        logic        giant;
    } vec_t;

    logic gmii_clk;
    logic rst;
    rx_frame_check_if bus ();

    rx_frame_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .gmii_clk (gmii_clk),
        .rst      (rst),
        .fc_io    (bus)
    );

    int    total = 0;
    int    bad   = 0;
    int    n_out = 0;
    int    n_stat = 0;
    out_t  exp_out[$];
    stat_t exp_stat[$];
    vec_t  vecs[7];

    initial gmii_clk = 1'b0;
    always #5 gmii_clk = ~gmii_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge gmii_clk) begin
        if (bus.out_valid === 1'b1) begin
            out_t e;
            n_out++;
            if (exp_out.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected actual=%h required=none", bus.out_data);
            end else begin
                e = exp_out.pop_front();
                check("out_word", 64'({bus.out_data, bus.out_sop, bus.out_eop, bus.out_mod, bus.out_err}),
                      64'(e));
            end
        end
        if (bus.stat_valid === 1'b1) begin
            stat_t s;
            n_stat++;
            if (exp_stat.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stat_unexpected actual_len=%0d required=none", bus.stat_len);
            end else begin
                s = exp_stat.pop_front();
                check("stat_len", 64'(bus.stat_len), 64'(s.len));
                check("stat_flags", 64'({bus.stat_err_sfd, bus.stat_err_runt, bus.stat_err_giant,
                      bus.stat_err_trunc}), 64'({s.sfd, s.runt, s.giant, s.trunc}));
            end
        end
    end

    // One valid word every 4 cycles, as the gearbox produces.
    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] md);
        @(negedge gmii_clk);
        bus.in_data  = d;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_mod   = md;
        bus.in_valid = 1'b1;
        @(negedge gmii_clk);
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        repeat (2) @(negedge gmii_clk);
    endtask

    // stop_after >= 0 sends only that many payload words and no eop.
    task automatic send_frame(input logic [31:0] p0, input logic [31:0] p1, input int nw,
                              input logic [1:0] md, input logic fwd, input logic err_exp,
                              input int stop_after, input int id);
        int   n;
        logic last;
        logic [31:0] d;
        send_word(p0, 1'b1, 1'b0, 2'd0);
        send_word(p1, 1'b0, 1'b0, 2'd0);
        n = (stop_after >= 0) ? stop_after : nw;
        for (int i = 0; i < n; i++) begin
            last = (stop_after < 0) && (i == nw - 1);
            d = 32'hC0DE_0000 ^ (id << 20) ^ i;
            if (fwd) exp_out.push_back('{d, (i == 0), last, (last ? md : 2'd0), (last ? err_exp : 1'b0)});
            send_word(d, 1'b0, last, last ? md : 2'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int before_out;
        int before_stat;
        int k;

        vecs[0] = '{32'h55555555, 32'h555555D5, 16,  2'd0, 1'b1, 16'd64,   1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h55555555, 32'h555555D5, 380, 2'd3, 1'b1, 16'd1519, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h55555555, 32'h555555D5, 16,  2'd1, 1'b1, 16'd61,   1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h55555555, 32'h555555D4, 18,  2'd0, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h55555554, 32'h555555D5, 16,  2'd0, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h55555555, 32'h555555D5, 380, 2'd2, 1'b1, 16'd1518, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h55555555, 32'h555555D5, 17,  2'd1, 1'b1, 16'd65,   1'b0, 1'b0, 1'b0};

        rst          = 1'b1;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_mod   = '0;
        repeat (3) @(negedge gmii_clk);
        check("reset_out", 64'({bus.out_data, bus.out_valid, bus.out_sop, bus.out_eop,
              bus.out_mod, bus.out_err}), 64'd0);
        check("reset_stat", 64'({bus.stat_valid, bus.stat_len, bus.stat_err_sfd, bus.stat_err_runt,
              bus.stat_err_giant, bus.stat_err_trunc}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge gmii_clk);

        for (int v = 0; v < 7; v++) begin
            exp_stat.push_back('{vecs[v].len, vecs[v].sfd, vecs[v].runt, vecs[v].giant, 1'b0});
            send_frame(vecs[v].p0, vecs[v].p1, vecs[v].nw, vecs[v].md, vecs[v].fwd,
                       vecs[v].runt | vecs[v].giant, -1, v);
        end

        // Truncated frame: new sop after 5 payload words, then a good frame.
        send_frame(32'h55555555, 32'h555555D5, 16, 2'd0, 1'b1, 1'b0, 5, 10);
        exp_out.push_back('{32'd0, 1'b0, 1'b1, 2'd0, 1'b1});
        exp_stat.push_back('{16'd20, 1'b0, 1'b1, 1'b0, 1'b1});
        exp_stat.push_back('{16'd64, 1'b0, 1'b0, 1'b0, 1'b0});
        send_frame(32'h55555555, 32'h555555D5, 16, 2'd0, 1'b1, 1'b0, -1, 11);

        // Single-word frame carrying both sop and eop.
        before_out = n_out;
        exp_stat.push_back('{16'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        send_word(32'h55555555, 1'b1, 1'b1, 2'd0);
        check("sopeop_no_out", 64'(n_out), 64'(before_out));

        // Valid word with no sop in IDLE.
        before_out  = n_out;
        before_stat = n_stat;
        send_word(32'hDEADBEEF, 1'b0, 1'b1, 2'd0);
        check("idle_nosop_out", 64'(n_out), 64'(before_out));
        check("idle_nosop_stat", 64'(n_stat), 64'(before_stat));

        // Reset in the middle of DATA.
        send_frame(32'h55555555, 32'h555555D5, 16, 2'd0, 1'b1, 1'b0, 3, 12);
        before_stat = n_stat;
        @(negedge gmii_clk);
        rst = 1'b1;
        #1;
        check("mrst_out", 64'({bus.out_data, bus.out_valid, bus.out_sop, bus.out_eop,
              bus.out_mod, bus.out_err}), 64'd0);
        check("mrst_stat", 64'({bus.stat_valid, bus.stat_len, bus.stat_err_sfd, bus.stat_err_runt,
              bus.stat_err_giant, bus.stat_err_trunc}), 64'd0);
        repeat (3) @(negedge gmii_clk);
        rst = 1'b0;
        before_out = n_out;
        send_word(32'h555555D5, 1'b0, 1'b0, 2'd0);
        send_word(32'h01020304, 1'b0, 1'b1, 2'd0);
        check("mrst_no_out", 64'(n_out), 64'(before_out));
        check("mrst_no_stat", 64'(n_stat), 64'(before_stat));
        exp_stat.push_back('{16'd64, 1'b0, 1'b0, 1'b0, 1'b0});
        send_frame(32'h55555555, 32'h555555D5, 16, 2'd0, 1'b1, 1'b0, -1, 13);

        k = 0;
        while ((exp_out.size() != 0 || exp_stat.size() != 0) && k < 40) begin
            @(negedge gmii_clk);
            k++;
        end
        check("drain_out", 64'(exp_out.size()), 64'd0);
        check("drain_stat", 64'(exp_stat.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
